gray_counter: RTL and testbench

- Synchronous up/down counter whose output is a registered, 4-bit-default reflected Gray code stream.
- Sits directly upstream of the gray-to-binary converter and is its stimulus source in lab setups.
- Each emitted code word is held under a valid/ready handshake, so a slow consumer stalls the count and no value is lost or skipped.

---
 rtl/gray_pkg.sv | 21 ++
 rtl/bin_to_gray.sv | 16 +
 rtl/gray_counter.sv | 61 ++++++
 tb/tb_gray_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared width default and Gray-code helpers for the Gray counter and its neighbours.
// Helpers work on a wide vector; callers zero-extend and truncate to their own WIDTH.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
  localparam int unsigned MAX_WIDTH          = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Terminal value: all-ones of 'width' bits when counting up, zero when counting down.
  function automatic logic is_terminal(input logic [MAX_WIDTH-1:0] cnt,
                                       input logic                 up,
                                       input int unsigned          width);
    logic [MAX_WIDTH-1:0] all_ones;
    all_ones = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    return up ? (cnt == all_ones) : (cnt == '0);
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-reflected-Gray mapping, WIDTH bits, no carry.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAX_WIDTH-1:0] gray_wide;

  assign gray_wide = bin2gray(MAX_WIDTH'(bin));
  assign gray      = gray_wide[WIDTH-1:0];

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter emitting its current value as a registered Gray word
// under a valid/ready handshake; the count only advances when a word is emitted.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] g_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_gray;
  logic             slot_free;
  logic             step;
  logic             terminal;

  bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
    .bin  (cnt),
    .gray (cnt_gray)
  );

  // Handshake: a word transfers on a rising edge where valid_out & ready_in.
  // While valid_out & ~ready_in, g_out/wrap/valid_out hold and the count is frozen.
  // A new word may be loaded in the same edge that the old one is taken.
  assign slot_free = ~valid_out | ready_in;
  assign step      = en & slot_free & ~load;
  assign terminal  = is_terminal(MAX_WIDTH'(cnt), up, WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      g_out     <= '0;
      valid_out <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (load) begin
        cnt <= load_bin;
      end else if (step) begin
        cnt <= up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
      end

      if (step) begin
        g_out <= cnt_gray;
        wrap  <= terminal;
      end

      // A load cycle never refills, but it still lets a pending word be consumed.
      valid_out <= step | (valid_out & ~ready_in);
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by a high-level integer model of the counter.
module tb_gray_counter;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic         ready_in = 1'b0;
  logic [W-1:0] g_out;
  logic         valid_out;
  logic         wrap;

  gray_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_bin  (load_bin),
    .g_out     (g_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .wrap      (wrap)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W:0]   exp_q[$];   // {wrap, gray word}
  logic [W-1:0] acc_q[$];   // every accepted word, in order
  int           checks = 0;
  int           errors = 0;
  int           m_cnt = 0;
  bit           m_valid_now = 1'b0;
  bit           m_valid_nxt = 1'b0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // Inputs change 2 time units after a rising edge; the model then predicts
  // what the coming edge does from the counting rules alone.
  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb, input logic rdy);
    int gray_v;
    bit term;
    @(posedge clk);
    #2;
    m_valid_now = m_valid_nxt;
    rst = r; en = e; up = u; load = l; load_bin = lb; ready_in = rdy;
    if (r) begin
      exp_q.delete();
      m_cnt       = 0;
      m_valid_nxt = 1'b0;
    end else if (l) begin
      m_cnt       = int'(lb);
      m_valid_nxt = m_valid_now && !rdy;
    end else if (e && (!m_valid_now || rdy)) begin
      gray_v = m_cnt ^ (m_cnt / 2);
      term   = u ? (m_cnt == N - 1) : (m_cnt == 0);
      exp_q.push_back({term, W'(gray_v)});
      m_cnt       = u ? (m_cnt + 1) % N : (m_cnt + N - 1) % N;
      m_valid_nxt = 1'b1;
    end else begin
      m_valid_nxt = m_valid_now && !rdy;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    acc_q.delete();
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic check_seq(input string name, input logic [W-1:0] want[$]);
    chk({name, "_count"}, acc_q.size(), want.size());
    for (int i = 0; i < want.size() && i < acc_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), int'(acc_q[i]), int'(want[i]));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W:0] e;
    if (mon_en) begin
      chk("valid_out", int'(valid_out), int'(m_valid_now));
      if (!rst && valid_out && ready_in) begin
        acc_q.push_back(g_out);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word", int'({wrap, g_out}), int'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] want[$];

    // Reset state
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("reset_g_out", int'(g_out), 0);
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_wrap", int'(wrap), 0);
    mon_en = 1'b1;

    // Count up through a full wrap
    do_reset();
    for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drain();
    want = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8, 4'h0};
    check_seq("up_seq", want);
    for (int i = 1; i < acc_q.size(); i++)
      chk($sformatf("one_bit[%0d]", i), $countones(acc_q[i] ^ acc_q[i-1]), 1);

    // Count down from reset
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    drain();
    want = '{4'h0, 4'h8, 4'h9, 4'hb};
    check_seq("down_seq", want);

    // Stall for 5 cycles after the first word
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drain();
    want = '{4'h0, 4'h1};
    check_seq("stall_seq", want);

    // Load wins over en in the same cycle
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drain();
    want = '{4'hf, 4'he};
    check_seq("load_seq", want);

    // Reset while a word is stalled
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("midrst_g_out", int'(g_out), 0);
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_wrap", int'(wrap), 0);
    acc_q.delete();
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drain();
    want = '{4'h0};
    check_seq("after_rst_seq", want);

    // Alternate direction from cnt=5
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    drain();
    want = '{4'h7, 4'h5, 4'h7, 4'h5};
    check_seq("alt_seq", want);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) == 0),
            W'($urandom_range(0, N - 1)),
            logic'($urandom_range(0, 3) != 0));
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
